oldland_fetch: RTL and testbench

//  Instruction fetch stage of the oldland CPU; sits between the instruction port of the

---
 rtl/oldland_fetch.sv | 73 +++++++
 tb/tb_oldland_fetch.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/oldland_fetch.sv
// rtl/oldland_fetch.sv - oldland instruction fetch stage with stall hold register and branch redirect
module oldland_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter logic [31:0] NOP_INSN     = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic        valid
);

  logic [31:0] addr_q, addr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        live;

  always_comb begin
    addr_d       = addr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_pc_d     = rsp_pc_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    if (branch_taken) begin
      addr_d       = {branch_pc[31:2], 2'b00};
      rsp_valid_d  = 1'b0;
      hold_valid_d = 1'b0;
    end else if (stall) begin
      // RAM re-reads addr_q during a stall, so the live word must be captured once.
      if (rsp_valid_q && !hold_valid_q) begin
        hold_instr_d = i_data;
        hold_valid_d = 1'b1;
      end
    end else begin
      rsp_pc_d     = addr_q;
      rsp_valid_d  = 1'b1;
      addr_d       = addr_q + 32'd4;
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= RESET_VECTOR;
      rsp_valid_q  <= 1'b0;
      rsp_pc_q     <= RESET_VECTOR;
      hold_valid_q <= 1'b0;
      hold_instr_q <= NOP_INSN;
    end else begin
      addr_q       <= addr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_pc_q     <= rsp_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign live      = hold_valid_q | rsp_valid_q;
  assign valid     = live & ~branch_taken & ~rst;
  assign instr     = !valid ? NOP_INSN : (hold_valid_q ? hold_instr_q : i_data);
  assign pc        = rsp_pc_q;
  assign pc_plus_4 = rsp_pc_q + 32'd4;
  assign i_addr    = addr_q;

endmodule

// File: tb/tb_oldland_fetch.sv
// tb/tb_oldland_fetch.sv - directed self-checking bench for oldland_fetch
module tb_oldland_fetch;
  localparam logic [31:0] NOP1 = 32'hDEAD0013;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] i_addr, i_data, instr, pc, pc_plus_4;
  logic        valid;
  logic [31:0] i_addr2, i_data2, instr2, pc2, pc_plus_42;
  logic        valid2;
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // RAM models: word at byte address a holds a>>2, one-cycle read latency.
  always_ff @(posedge clk) begin
    i_data  <= {2'b00, i_addr[31:2]};
    i_data2 <= {2'b00, i_addr2[31:2]};
  end

  oldland_fetch #(.RESET_VECTOR(32'h00000000), .NOP_INSN(NOP1)) dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .i_data(i_data), .stall(stall),
    .branch_taken(branch_taken), .branch_pc(branch_pc), .instr(instr), .pc(pc),
    .pc_plus_4(pc_plus_4), .valid(valid)
  );

  oldland_fetch #(.RESET_VECTOR(32'hFFFFFFF8), .NOP_INSN(32'h00000000)) dut2 (
    .clk(clk), .rst(rst), .i_addr(i_addr2), .i_data(i_data2), .stall(stall),
    .branch_taken(branch_taken), .branch_pc(branch_pc), .instr(instr2), .pc(pc2),
    .pc_plus_4(pc_plus_42), .valid(valid2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_live(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc);
    chk({tag, ".valid"}, {31'd0, valid}, 32'd1);
    chk({tag, ".instr"}, instr, e_instr);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".pc_plus_4"}, pc_plus_4, e_pc + 32'd4);
  endtask

  task automatic exp_dead(input string tag);
    chk({tag, ".valid"}, {31'd0, valid}, 32'd0);
    chk({tag, ".instr"}, instr, NOP1);
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_pc = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    exp_dead("release");
    chk("release.i_addr", i_addr, 32'h0);
  endtask

  task automatic branch_scenario(input string tag, input logic with_stall);
    do_reset();
    tick(); #1; exp_live({tag, ".pc0"}, 32'd0, 32'h0);
    tick();
    branch_taken = 1'b1; branch_pc = 32'h103; stall = with_stall;
    #1; exp_dead({tag, ".br_cycle"});
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    #1; exp_dead({tag, ".bubble"});
    chk({tag, ".i_addr_target"}, i_addr, 32'h100);
    tick(); #1; exp_live({tag, ".t0"}, 32'h40, 32'h100);
    tick(); #1; exp_live({tag, ".t1"}, 32'h41, 32'h104);
  endtask

  initial begin
    // Reset state, both instances.
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_pc = '0;
    tick(); #1;
    exp_dead("rst");
    chk("rst.i_addr", i_addr, 32'h0);
    chk("rst.pc", pc, 32'h0);
    chk("rst2.i_addr", i_addr2, 32'hFFFFFFF8);
    chk("rst2.valid", {31'd0, valid2}, 32'd0);

    // Scenario 1 + wrap on dut2.
    tick();
    rst = 1'b0;
    #1; exp_dead("rel1");
    tick(); #1; exp_live("s1.c1", 32'd0, 32'h0);
    chk("s1.i_addr", i_addr, 32'h4);
    chk("wrap.pc0", pc2, 32'hFFFFFFF8);
    chk("wrap.instr0", instr2, 32'h3FFFFFFE);
    tick(); #1; exp_live("s1.c2", 32'd1, 32'h4);
    chk("wrap.pc1", pc2, 32'hFFFFFFFC);
    chk("wrap.pc_plus_4_1", pc_plus_42, 32'h0);
    chk("wrap.instr1", instr2, 32'h3FFFFFFF);
    tick();
    stall = 1'b1;
    #1; exp_live("s2.st0", 32'd2, 32'h8);
    chk("wrap.pc2_stalled", pc2, 32'h0);
    tick(); #1; exp_live("s2.st1", 32'd2, 32'h8);
    chk("s2.i_addr_held", i_addr, 32'hC);
    tick(); #1; exp_live("s2.st2", 32'd2, 32'h8);
    tick();
    stall = 1'b0;
    #1; exp_live("s2.release", 32'd2, 32'h8);
    tick(); #1; exp_live("s2.next0", 32'd3, 32'hC);
    tick(); #1; exp_live("s2.next1", 32'd4, 32'h10);

    // Scenarios 3 and 4.
    branch_scenario("s3", 1'b0);
    branch_scenario("s4", 1'b1);

    // Scenario 5: reset mid-stall with hold loaded.
    do_reset();
    tick(); #1; exp_live("s5.pc0", 32'd0, 32'h0);
    tick();
    stall = 1'b1;
    #1; exp_live("s5.st0", 32'd1, 32'h4);
    tick(); #1; exp_live("s5.st1", 32'd1, 32'h4);
    rst = 1'b1;
    #1; exp_dead("s5.in_rst");
    tick();
    rst = 1'b0; stall = 1'b0;
    #1; exp_dead("s5.release");
    chk("s5.i_addr", i_addr, 32'h0);
    tick(); #1; exp_live("s5.restart0", 32'd0, 32'h0);
    tick(); #1; exp_live("s5.restart1", 32'd1, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
